// File: rtl/frame_sync_if.sv
// frame_sync_if: byte-stream valid/ready link used on both sides of frame_sync.
// The master drives data/valid and the slave drives ready.
interface frame_sync_if #(
  parameter int BusWidth = 8
);
  logic [BusWidth-1:0] data;
  logic                valid;
  logic                ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/frame_sync.sv
// frame_sync: hunts for a two-byte header, forwards PayloadBytes bytes with zero
// latency, then checks a two-byte tail and reports framing faults.
// Optional feature: define FRAME_SYNC_TIMEOUT_EN to abandon frames idle for
// TimeoutCycles cycles.
module frame_sync #(
  parameter int                  BusWidth      = 8,
  parameter int                  PayloadBytes  = 9600,
  parameter logic [BusWidth-1:0] HeadByte0     = 'hA5,
  parameter logic [BusWidth-1:0] HeadByte1     = 'h5A,
  parameter logic [BusWidth-1:0] TailByte0     = 'h0D,
  parameter logic [BusWidth-1:0] TailByte1     = 'h0A,
  parameter int unsigned         TimeoutCycles = 250000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  frame_sync_if.slave         up,
  frame_sync_if.master        dn,
  output logic                sof_o,
  output logic                locked_o,
  output logic                frame_done_o,
  output logic                frame_err_o,
  output logic [7:0]          err_count_o
);

  // A one-byte payload still needs a one-bit counter.
  localparam int CntW = (PayloadBytes > 1) ? $clog2(PayloadBytes) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(PayloadBytes - 1);

  if ((PayloadBytes < 1) || (TimeoutCycles < 1)) begin : g_param_check
    $error("frame_sync: PayloadBytes and TimeoutCycles must be at least 1");
  end

  typedef enum logic [2:0] {
    HUNT,
    HEAD1,
    PAYLOAD,
    TAIL0,
    TAIL1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CntW-1:0] cnt;
  logic            accept;
  logic            fault;
  logic            done;
  logic            timeout;

  // A byte is consumed whenever upstream offers it and we are ready for it.
  always_comb begin
    accept = up.valid & up.ready;
  end

`ifdef FRAME_SYNC_TIMEOUT_EN
  localparam int IdleW = $clog2(TimeoutCycles + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TimeoutCycles - 1);

  logic [IdleW-1:0] idle_cnt;

  // Fire on the idle cycle that brings the count to TimeoutCycles.
  always_comb begin
    timeout = locked_o & ~up.valid & (idle_cnt == IdleLast);
  end

  // Idle counter: counts valid-low cycles while locked, cleared by any valid
  // cycle (stalled or not) and on every state change.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_cnt <= '0;
    end else if ((state_next != state) || !locked_o || up.valid) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IdleW'(1);
    end
  end
`else
  always_comb begin
    timeout = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and fault/done decode; only an accepted byte (or a timeout) moves the FSM.
  always_comb begin
    state_next = state;
    fault      = 1'b0;
    done       = 1'b0;
    if (timeout) begin
      state_next = HUNT;
      fault      = 1'b1;
    end else if (accept) begin
      unique case (state)
        HUNT: begin
          if (up.data == HeadByte0) state_next = HEAD1;
        end
        HEAD1: begin
          if (up.data == HeadByte1)      state_next = PAYLOAD;
          else if (up.data == HeadByte0) state_next = HEAD1;
          else                           state_next = HUNT;
        end
        PAYLOAD: begin
          if (cnt == LastCnt) state_next = TAIL0;
        end
        TAIL0: begin
          if (up.data == TailByte0) begin
            state_next = TAIL1;
          end else begin
            state_next = HUNT;
            fault      = 1'b1;
          end
        end
        TAIL1: begin
          state_next = HUNT;
          if (up.data == TailByte1) done  = 1'b1;
          else                      fault = 1'b1;
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // Output decode: pass-through in PAYLOAD, otherwise swallow bytes.
  always_comb begin
    up.ready = 1'b1;
    dn.valid = 1'b0;
    dn.data  = '0;
    locked_o = 1'b0;
    sof_o    = 1'b0;
    unique case (state)
      PAYLOAD: begin
        up.ready = dn.ready;
        dn.valid = up.valid;
        dn.data  = up.data;
        locked_o = 1'b1;
        sof_o    = (cnt == '0) & up.valid;
      end
      TAIL0, TAIL1: locked_o = 1'b1;
      default: ;
    endcase
  end

  // Payload byte counter, cleared by the second header byte and after the last byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if ((state == HEAD1) && accept && (up.data == HeadByte1)) begin
      cnt <= '0;
    end else if ((state == PAYLOAD) && accept) begin
      cnt <= (cnt == LastCnt) ? '0 : cnt + CntW'(1);
    end
  end

  // Registered status pulses and the saturating fault counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;
      err_count_o  <= '0;
    end else begin
      frame_done_o <= done;
      frame_err_o  <= fault;
      if (fault && (err_count_o != '1)) begin
        err_count_o <= err_count_o + 8'd1;
      end
    end
  end

endmodule

// File: doc/frame_sync.md
# frame_sync

Byte-stream frame synchronizer between the UART receive skid buffer and the pixel unpacker. It hunts for a two-byte header in the incoming AXIS-style byte stream and forwards exactly `PayloadBytes` packed-pixel bytes downstream with zero latency. It then checks a two-byte tail and flags any framing fault. Downstream line and pixel counters can never drift out of alignment: every frame they see is preceded by a validated header, and every fault is reported.

## Interface
- `BusWidth`, 8, byte width of the stream.
- `PayloadBytes`, 9600, payload bytes per frame (320×240 1-bit pixels / 8).
- `HeadByte0`, 8'hA5, first header byte.
- `HeadByte1`, 8'h5A, second header byte.
- `TailByte0`, 8'h0D, first tail byte.
- `TailByte1`, 8'h0A, second tail byte.
- `TimeoutCycles`, 250000, idle-cycle limit inside a frame; used only with `FRAME_SYNC_TIMEOUT_EN`.

Ports. One clock; reset is asynchronous and active-low.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `data_i` in BusWidth: byte from skid buffer.
- `valid_i` in 1: upstream valid.
- `ready_o` out 1: upstream ready.
- `data_o` out BusWidth: payload byte to unpacker.
- `valid_o` out 1: downstream valid.
- `ready_i` in 1: downstream ready.
- `sof_o` out 1: high with the first payload byte of a frame.
- `locked_o` out 1: high in PAYLOAD, TAIL0 and TAIL1.
- `frame_done_o` out 1: one-cycle pulse when a frame completes with a good tail.
- `frame_err_o` out 1: one-cycle pulse on any framing fault.
- `err_count_o` out 8: saturating count of framing faults.

## Operation
- FSM states: HUNT, HEAD1, PAYLOAD, TAIL0, TAIL1. Payload counter is `$clog2(PayloadBytes)` bits wide.
- In HUNT, HEAD1, TAIL0 and TAIL1:
  - `ready_o`=1 and `valid_o`=0.
  - Bytes are consumed and never forwarded.
- In PAYLOAD:
  - Combinational pass-through: `data_o`=`data_i`, `valid_o`=`valid_i`, `ready_o`=`ready_i`.
  - A transfer is `valid_i & ready_i`.
- State transitions, evaluated only on an accepted byte:
  - HUNT: `HeadByte0` goes to HEAD1; any other byte stays in HUNT.
  - HEAD1: `HeadByte1` goes to PAYLOAD and clears the counter. `HeadByte0` stays in HEAD1. Any other byte goes to HUNT.
  - PAYLOAD: each transfer increments the counter. The transfer at count `PayloadBytes-1` goes to TAIL0.
  - TAIL0: `TailByte0` goes to TAIL1. Any other byte is a fault and goes to HUNT.
  - TAIL1: `TailByte1` pulses `frame_done_o` and goes to HUNT. Any other byte is a fault and goes to HUNT.
- Faults:
  - A fault pulses `frame_err_o` and increments `err_count_o`.
  - `err_count_o` saturates at 255; it never wraps.
  - A byte that triggers a fault is discarded; it is not re-examined as a header.
- `sof_o` = PAYLOAD & counter==0 & `valid_o`.
- A header byte pattern appearing inside the payload is data, not a resync.

## Timing
- Payload latency is 0 cycles (combinational path from `data_i` to `data_o`).
- State, counter and pulses update on the rising edge after an accepted byte.
  - `frame_done_o` and `frame_err_o` are registered; they are high the cycle after the offending or completing byte is accepted.
- Reset (async assert, sync deassert at source), values held until the first accepted byte:
  - State HUNT, counter 0, `err_count_o`=0.
  - `frame_done_o`=0, `frame_err_o`=0, `locked_o`=0, `sof_o`=0, `valid_o`=0, `ready_o`=1.
- Reset asserted mid-frame abandons the frame with no error counted. Downstream reset shares `rst_ni`.
- When `ready_i`=0 in PAYLOAD:
  - `ready_o`=0 and the upstream skid buffer holds the byte.
  - `valid_o` may rise without `ready_i`; AXIS rule: `data_o` stays stable while `valid_o` is high and `ready_i` is low.
- `PayloadBytes`=1: the header goes directly into a one-byte PAYLOAD, then TAIL0.

## Configuration
- `FRAME_SYNC_TIMEOUT_EN` defined:
  - An idle counter runs in PAYLOAD, TAIL0 and TAIL1. It increments on cycles with `valid_i`=0 and clears on any cycle with `valid_i`=1.
  - Backpressure cycles (`valid_i`=1, `ready_i`=0) do not count.
  - When the counter reaches `TimeoutCycles`: go to HUNT, pulse `frame_err_o`, increment `err_count_o`.
  - The counter clears on state entry.
- Not defined: no idle counter, no timeout logic. `TimeoutCycles` is ignored and a stalled frame waits indefinitely.

## Test plan
Bench settings: `PayloadBytes`=4; `TimeoutCycles`=16 for the timeout case.
- Clean frame: bytes A5 5A 11 22 33 44 0D 0A.
  - Downstream receives 11 22 33 44, with `sof_o` on 11.
  - `frame_done_o` pulses once; `err_count_o`=0.
- Garbage then frame: 00 A5 A5 5A 01 02 03 04 0D 0A.
  - Leading 00 is dropped and the repeated A5 is tolerated.
  - Payload 01 02 03 04 is forwarded; no error.
- Bad tail: A5 5A 01 02 03 04 0D FF, then a clean frame.
  - `frame_err_o` pulses once and `err_count_o`=1.
  - The following clean frame is forwarded correctly.
- Backpressure: `ready_i` toggles 1/0 every cycle during the payload.
  - Each byte is forwarded exactly once, in order.
  - `data_o` is stable while stalled; `ready_o` mirrors `ready_i`.
- Reset mid-payload: drop `rst_ni` after 2 payload bytes.
  - All outputs return to their reset values; `err_count_o`=0.
  - The next clean frame passes intact.
- With the macro defined: header plus 2 payload bytes, then `valid_i`=0 for 16 cycles.
  - `frame_err_o` pulses, state is HUNT, `err_count_o`=1.
  - Without the macro, the same stimulus gives no error and `locked_o` stays 1.
